// File: rtl/vscpu_pkg.sv
// Shared constants for the VSCPU memory-mapped bus: MMIO map, STATUS layout and FIFO sizing.
package vscpu_pkg;

    localparam logic [13:0] MMIO_BASE  = 14'h3FF0;
    localparam logic [3:0]  OFF_OUT    = 4'h0;
    localparam logic [3:0]  OFF_STATUS = 4'h1;
    localparam logic [3:0]  OFF_CYCLE  = 4'h2;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;

    typedef enum logic {
        SEL_RAM  = 1'b0,
        SEL_MMIO = 1'b1
    } sel_e;

    function automatic logic [31:0] status_word(input logic empty,
                                                input logic full,
                                                input logic ovf,
                                                input logic [CNT_W-1:0] count);
        logic [31:0] w;
        w = '0;
        w[ST_EMPTY] = empty;
        w[ST_FULL] = full;
        w[ST_OVF] = ovf;
        w[ST_CNT_LSB +: CNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/vscpu_out_fifo.sv
// Byte output FIFO with sticky overflow flag; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module vscpu_out_fifo
    import vscpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    input  logic             ovf_clr,
    output logic [7:0]       data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign data     = mem[rd_ptr];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
            // A clear in the same cycle as a dropped push wins.
            if (ovf_clr) overflow <= 1'b0;
            else if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/vscpu_mmio_bus.sv
// CPU bus splitter: RAM below MMIO_BASE, OUT/STATUS/CYCLE registers above it, with a
// uniform one-cycle read latency on both paths.
module vscpu_mmio_bus
    import vscpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wrEn,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_we,
    output logic [13:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    logic             is_mmio;
    logic [3:0]       offset;
    logic             wr_out;
    logic             wr_status;
    logic             wr_cycle;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_ovf;
    logic             pop;
    logic [31:0]      cycle;
    logic [31:0]      mmio_rd;
    logic [31:0]      mmio_q;
    sel_e             sel_q;

    assign is_mmio   = (cpu_addr >= MMIO_BASE);
    assign offset    = cpu_addr[3:0];
    // Qualify with the strobe first so an unknown address with wrEn low decodes to no write.
    assign wr_out    = cpu_wrEn && is_mmio && (offset == OFF_OUT);
    assign wr_status = cpu_wrEn && is_mmio && (offset == OFF_STATUS);
    assign wr_cycle  = cpu_wrEn && is_mmio && (offset == OFF_CYCLE);

    assign ram_we    = cpu_wrEn && !is_mmio;
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    vscpu_out_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_out),
        .push_data (cpu_wdata[7:0]),
        .pop       (pop),
        .ovf_clr   (wr_status),
        .data      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

    always_comb begin
        mmio_rd = '0;
        case (offset)
            OFF_STATUS: mmio_rd = status_word(fifo_empty, fifo_full, fifo_ovf, fifo_count);
            OFF_CYCLE:  mmio_rd = cycle;
            default:    mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle  <= '0;
            sel_q  <= SEL_RAM;
            mmio_q <= '0;
        end else begin
            cycle  <= wr_cycle ? cpu_wdata : cycle + 32'd1;
            sel_q  <= is_mmio ? SEL_MMIO : SEL_RAM;
            mmio_q <= mmio_rd;
        end
    end

    assign cpu_rdata = (sel_q == SEL_RAM) ? ram_rdata : mmio_q;

endmodule

// File: tb/tb_vscpu_mmio_bus.sv
// Bench for vscpu_mmio_bus: behavioural RAM, read-data and output-byte scoreboards.
module tb_vscpu_mmio_bus;

    localparam logic [13:0] A_OUT    = 14'h3FF0;
    localparam logic [13:0] A_STATUS = 14'h3FF1;
    localparam logic [13:0] A_CYCLE  = 14'h3FF2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wrEn;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic [31:0] mem [16384];
    logic [31:0] exp_q [$];
    logic [31:0] rd_q [$];
    logic [7:0]  exp_b [$];
    logic [7:0]  got_b [$];
    int n_tests = 0;
    int n_fail = 0;

    vscpu_mmio_bus dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_wrEn  (cpu_wrEn),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Handshake values are stable at the falling edge; a pop happens on the next rise.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_b.push_back(out_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [13:0] a, input logic [31:0] d, input logic chk);
        cpu_wrEn  = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        cyc();
        if (chk) rd_q.push_back(cpu_rdata);
        cpu_wrEn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_wrEn = 1'b0; cpu_addr = 'x; cpu_wdata = 'x; out_ready = 1'b0;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we_x_addr: got %b want 0", ram_we); end
        cyc(); cyc();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        cpu_wdata = '0;
        rst = 1'b0;
        exp_q.push_back(32'h0); bus(1'b0, A_CYCLE, 32'h0, 1'b1);
        exp_q.push_back(32'h1); bus(1'b0, A_CYCLE, 32'h0, 1'b1);
        exp_q.push_back(32'h1); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL reset_read: got %h want %h", g, e); end
        end
    endtask

    task automatic test_ram();
        cpu_wrEn = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 32'h12345678;
        #1;
        n_tests++;
        if (ram_we !== 1'b1 || ram_addr !== 14'h0100 || ram_wdata !== 32'h12345678) begin
            n_fail++; $display("FAIL ram_write_port: got we=%b a=%h d=%h want 1/0100/12345678", ram_we, ram_addr, ram_wdata);
        end
        cyc(); cpu_wrEn = 1'b0;
        cpu_wrEn = 1'b1; cpu_addr = 14'h3FEF; cpu_wdata = 32'hCAFEF00D;
        #1;
        n_tests++;
        if (ram_we !== 1'b1) begin n_fail++; $display("FAIL ram_top_we: got %b want 1", ram_we); end
        cyc(); cpu_wrEn = 1'b0;
        exp_q.push_back(32'h12345678); bus(1'b0, 14'h0100, 32'h0, 1'b1);
        exp_q.push_back(32'hCAFEF00D); bus(1'b0, 14'h3FEF, 32'h0, 1'b1);
        exp_q.push_back(32'h12345678); bus(1'b0, 14'h0100, 32'h0, 1'b1);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL ram_read: got %h want %h", g, e); end
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        got_b.delete(); exp_b.delete();
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, A_OUT, 32'hFFFF_FF00 | 32'(8'h41 + i), 1'b0);
            if (i == 3) begin exp_q.push_back(32'h22); bus(1'b0, A_STATUS, 32'h0, 1'b1); end
        end
        exp_q.push_back(32'h26); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        bus(1'b1, A_STATUS, 32'h0, 1'b0);
        exp_q.push_back(32'h22); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) exp_b.push_back(8'(8'h41 + i));
        cpu_addr = 14'h0000;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) cyc();
        n_tests++;
        if (out_valid) begin n_fail++; $display("FAIL ovf_drain_timeout: out_valid=%b want 0", out_valid); end
        exp_q.push_back(32'h01); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL ovf_status: got %h want %h", g, e); end
        end
        n_tests++;
        if (got_b.size() != exp_b.size()) begin n_fail++; $display("FAIL ovf_byte_count: got %0d want %0d", got_b.size(), exp_b.size()); end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            logic [7:0] e, g;
            e = exp_b.pop_front(); g = got_b.pop_front();
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL ovf_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        got_b.delete(); exp_b.delete();
        for (int i = 0; i < 4; i++) bus(1'b1, A_OUT, 32'(8'h11 + i), 1'b0);
        out_ready = 1'b1;
        bus(1'b1, A_OUT, 32'h55, 1'b0);
        out_ready = 1'b0;
        exp_q.push_back(32'h22); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        for (int i = 1; i < 4; i++) exp_b.push_back(8'(8'h11 + i));
        exp_b.push_front(8'h11);
        exp_b.push_back(8'h55);
        cpu_addr = 14'h0000;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) cyc();
        n_tests++;
        if (out_valid) begin n_fail++; $display("FAIL fpp_drain_timeout: out_valid=%b want 0", out_valid); end
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL fpp_status: got %h want %h", g, e); end
        end
        n_tests++;
        if (got_b.size() != exp_b.size()) begin n_fail++; $display("FAIL fpp_byte_count: got %0d want %0d", got_b.size(), exp_b.size()); end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            logic [7:0] e, g;
            e = exp_b.pop_front(); g = got_b.pop_front();
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL fpp_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_cycle();
        bus(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
        exp_q.push_back(32'hFFFF_FFFE); bus(1'b0, A_CYCLE, 32'h0, 1'b1);
        exp_q.push_back(32'hFFFF_FFFF); bus(1'b0, A_CYCLE, 32'h0, 1'b1);
        exp_q.push_back(32'h0000_0000); bus(1'b0, A_CYCLE, 32'h0, 1'b1);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL cycle_wrap: got %h want %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        got_b.delete();
        for (int i = 0; i < 3; i++) bus(1'b1, A_OUT, 32'(8'hA1 + i), 1'b0);
        exp_q.push_back(32'h18); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        rst = 1'b1;
        cyc();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        rst = 1'b0;
        exp_q.push_back(32'h0); bus(1'b0, A_CYCLE, 32'h0, 1'b1);
        exp_q.push_back(32'h1); bus(1'b0, A_CYCLE, 32'h0, 1'b1);
        exp_q.push_back(32'h01); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        out_ready = 1'b1;
        cpu_addr = 14'h0000;
        repeat (4) cyc();
        n_tests++;
        if (got_b.size() != 0) begin n_fail++; $display("FAIL rstmid_stale_bytes: got %0d want 0", got_b.size()); end
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL rstmid_read: got %h want %h", g, e); end
        end
    endtask

    task automatic test_unmapped();
        out_ready = 1'b0;
        got_b.delete(); exp_b.delete();
        cpu_wrEn = 1'b1; cpu_addr = A_OUT; cpu_wdata = 32'h77;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL out_ram_we: got %b want 0", ram_we); end
        cyc();
        cpu_addr = 14'h3FF5; cpu_wdata = 32'hDEAD_0000;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL unmapped_ram_we: got %b want 0", ram_we); end
        cyc(); cpu_wrEn = 1'b0;
        exp_q.push_back(32'h0);  bus(1'b0, 14'h3FF5, 32'h0, 1'b1);
        exp_q.push_back(32'h0);  bus(1'b0, A_OUT, 32'h0, 1'b1);
        exp_q.push_back(32'h08); bus(1'b0, A_STATUS, 32'h0, 1'b1);
        n_tests++;
        if (mem[14'h3FF5] !== 32'h0 || mem[14'h3FF0] !== 32'h0) begin
            n_fail++; $display("FAIL mmio_leak_to_ram: got %h/%h want 0/0", mem[14'h3FF0], mem[14'h3FF5]);
        end
        exp_b.push_back(8'h77);
        cpu_addr = 14'h0000;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) cyc();
        n_tests++;
        if (out_valid) begin n_fail++; $display("FAIL unmapped_drain_timeout: out_valid=%b want 0", out_valid); end
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL unmapped_read: got %h want %h", g, e); end
        end
        n_tests++;
        if (got_b.size() != 1 || got_b[0] !== exp_b[0]) begin
            n_fail++; $display("FAIL unmapped_bytes: got n=%0d first=%h want n=1 first=%h", got_b.size(), (got_b.size() > 0) ? got_b[0] : 8'h00, exp_b[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
        test_reset();
        test_ram();
        test_overflow();
        test_full_push_pop();
        test_cycle();
        test_reset_mid();
        test_unmapped();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vscpu_mmio_bus.md
VSCPU_MMIO_BUS -- requirements
Module: vscpu_mmio_bus

Interface
REQ-001 SHALL use these ports: clk input 1, system clock; all state changes on posedge clk.
REQ-002 SHALL use rst input 1: reset, synchronous, active-high.
REQ-003 SHALL use cpu_wrEn input 1: CPU write strobe.
REQ-004 SHALL use cpu_addr input 14: CPU word address.
REQ-005 SHALL use cpu_wdata input 32: CPU write data.
REQ-006 SHALL use cpu_rdata output 32: read data to CPU, valid the cycle after the address.
REQ-007 SHALL use ram_we output 1, ram_addr output 14, ram_wdata output 32 and ram_rdata input 32: synchronous RAM port with 1-cycle read latency.
REQ-008 SHALL use out_data output 8, out_valid output 1 and out_ready input 1: byte output stream with a valid/ready handshake.

Function
REQ-009 SHALL decode addresses 14'h0000-14'h3FEF as RAM and 14'h3FF0-14'h3FFF as MMIO.
REQ-010 SHALL drive the RAM side combinationally: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_wrEn AND RAM region; MMIO writes never reach RAM.
REQ-011 SHALL register the region select and the MMIO read value at each posedge; cpu_rdata = ram_rdata when the registered select is RAM, else the registered MMIO value (1-cycle latency in both cases).
REQ-012 SHALL implement 14'h3FF0 OUT write: push cpu_wdata[7:0] into a 4-entry FIFO; reads return 0.
REQ-013 SHALL implement 14'h3FF1 STATUS read: bit0 empty, bit1 full, bit2 overflow (sticky), bits[5:3] count 0-4, others 0; any write clears overflow.
REQ-014 SHALL implement 14'h3FF2 CYCLE: 32-bit counter, +1 every cycle, wraps FFFFFFFF->0; a write loads cpu_wdata; reads return the pre-edge value.
REQ-015 SHALL make 14'h3FF3-14'h3FFF read 0 and ignore writes to them.
REQ-016 SHALL drive out_valid = FIFO not empty and out_data = FIFO head; a pop occurs when out_valid AND out_ready.
REQ-017 SHALL drop a push when the FIFO is full with no pop in the same cycle, leave FIFO contents unchanged, and set overflow.
REQ-018 SHALL accept both a push and a pop in the same cycle while full; count is unchanged and overflow is not set.
REQ-019 SHALL perform only the push on push while empty (no pop since out_valid=0); out_valid rises the next cycle.
REQ-020 SHALL give a CYCLE write priority over the increment in the same cycle.
REQ-021 SHALL give an overflow-clearing write priority over a simultaneous overflow event (result is cleared).
REQ-022 SHALL return STATUS/CYCLE reads from state before that cycle's updates.
REQ-023 SHALL treat cpu_wrEn=0 as no write regardless of cpu_addr, including X/unknown addresses.

Reset
REQ-024 SHALL, while rst is high, set the FIFO empty (pointers 0, count 0), overflow=0, CYCLE=0, registered select=RAM, registered MMIO value=0, out_valid=0.
REQ-025 SHALL discard queued bytes on rst mid-operation; out_valid drops the cycle after rst is sampled.
REQ-026 SHALL leave ram_we combinational and gated only by cpu_wrEn/decode; the CPU holds wrEn low during reset.

Structure
REQ-027 SHALL place MMIO_BASE=14'h3FF0, the register offsets (OUT=0, STATUS=1, CYCLE=2), FIFO_DEPTH=4 and the STATUS bit positions in the shared package vscpu_pkg.
REQ-028 SHALL implement the FIFO as sub-module vscpu_out_fifo (push, pop, data, empty, full, count, overflow); decode, counter and read mux stay in the top module.

Verification
REQ-029 SHALL cover: write 32'h12345678 to 14'h0100, then read 14'h0100 -> ram_we=1 on the write, cpu_rdata=32'h12345678 one cycle after the read address.
REQ-030 SHALL cover: out_ready=0, write 0x41,0x42,0x43,0x44,0x45 to 3FF0 -> STATUS=0x22 then 0x26 after the 5th write; raise out_ready -> 0x41..0x44 emitted in order, 0x45 absent.
REQ-031 SHALL cover: FIFO full, out_ready=1, write 0x55 -> STATUS count stays 4, overflow stays 0, 0x55 emitted last.
REQ-032 SHALL cover: write 32'hFFFFFFFE to 3FF2 -> reads on successive cycles return FFFFFFFE, FFFFFFFF, 00000000.
REQ-033 SHALL cover: three bytes queued, pulse rst 1 cycle -> out_valid=0, STATUS=0x01, CYCLE restarts at 0.
REQ-034 SHALL cover: write to 3FF0 and to 3FF5 -> ram_we stays 0; reading 3FF5 -> 0.
